operand_forwarding_unit: RTL
============================

# operand_forwarding_unit

Hazard-tracking and operand-forwarding stage placed directly after the 32×32 register file in the RISC-V pipeline. It tracks destination registers of instructions in EX, MEM and WB. It drives the register file write port (RW/PW/enable) from the WB slot. It replaces stale PA/PB values with in-flight results and raises a load-use stall when forwarding cannot resolve the hazard.

## Interface
- XLEN, 32, datapath width
- RADDR_W, 5, register index width
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all tracking state
- id_valid  in  1  decode slot holds a real instruction
- id_rs1, id_rs2  in  RADDR_W  source indices (also drive register file RA/RB)
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_rd  in  RADDR_W  destination index
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- flush  in  1  taken branch/jump; squash decode instruction
- rf_pa, rf_pb  in  XLEN  register file read ports
- ex_result, mem_result, wb_result  in  XLEN  results currently in EX, MEM (ALU result or load data), WB
- op_a, op_b  out  XLEN  resolved operands to ID/EX register
- fwd_sel_a, fwd_sel_b  out  2  source code: 0 RF, 1 EX, 2 MEM, 3 WB
- stall  out  1  hold PC and IF/ID; insert bubble into EX
- rf_we, rf_rw, rf_pw  out  1/RADDR_W/XLEN  register file write enable, index, data

## Operation
- Tracking pipeline: three slots EX, MEM, WB, each {valid, rd, we, is_load}. On each edge: WB←MEM, MEM←EX, EX←decode entry.
- Decode entry = {id_valid, id_rd, id_rd_we, id_is_load}. A bubble (valid=0) is used instead when stall=1 or flush=1.
- A slot matches source rs when valid & we & rd==rs & rs!=0 & use_rsN.
- Operand priority: EX match (non-load) > MEM match > WB match > rf. x0 always selects RF (fwd_sel=0), so op=0.
- Load-use: EX match with EX.is_load=1 → stall=1. During stall the operand skips EX and resolves MEM > WB > RF. Downstream discards it because EX receives a bubble.
- WB forwarding is mandatory: the register file writes at the same edge, so the read in that cycle returns the old value.
- rf_we = WB.valid & WB.we & WB.rd!=0; rf_rw = WB.rd; rf_pw = wb_result.
- flush and stall both asserted: flush wins. stall forced 0 and EX loads a bubble.
- Stall holds the decode inputs unchanged, so the hazard re-evaluates next cycle. It clears once the load reaches MEM, where it forwards from mem_result.

## Timing
- op_a/op_b, fwd_sel, stall, and rf_* are combinational from current slots and inputs. No added latency.
- Slot state advances one stage per clk edge. Load-use costs exactly one stall cycle.
- Reset (including mid-operation) at the edge: all slot valid=0.
  - Next cycle: stall=0, rf_we=0, fwd_sel=0, op_a=rf_pa, op_b=rf_pb.
  - In-flight writes are dropped.
- Same rd in EX and MEM: the EX (youngest) value is used.

## Structure
- Shared package: XLEN/RADDR_W constants, FWD_RF/FWD_EX/FWD_MEM/FWD_WB codes, slot struct type {valid, rd, we, is_load}.
- Sub-module operand_select, instantiated twice (A, B). It takes the rs index, use flag, three slots, three result buses and the rf value. It outputs the operand, fwd_sel and a load-hit flag. Top level ORs the load-hit flags into stall.

## Test plan
- Back-to-back ALU: write x5=0x11 then read x5 next instruction → fwd_sel_a=1, op_a=ex_result=0x11, stall=0.
- Distance 2 and 3: reader of x7 two/three instructions after writer.
  - Distance 2: fwd_sel=2, op=mem_result.
  - Distance 3: fwd_sel=3, op=wb_result, with rf_we=1, rf_rw=7 in the same cycle.
  - Next cycle the rf value matches.
- Load-use: lw x3 followed by add using x3.
  - stall=1 for exactly one cycle.
  - Following cycle: fwd_sel=2, op=mem_result=0xDEADBEEF.
- x0 writer followed by x0 reader → fwd_sel=0, op=0, rf_we=0.
- Flush during load-use stall → stall=0, EX bubble. Two cycles later rf_we=0 for the squashed slot.
- Reset asserted with three valid writers in flight → next cycle rf_we=0, stall=0, fwd_sel_a=fwd_sel_b=0.

Source files
------------

// File: rtl/operand_forwarding_unit_pkg.sv
// ---------------------------------------------------------------------------
// operand_forwarding_unit_pkg
// Shared definitions for the operand forwarding / hazard tracking stage that
// sits behind the 32x32 register file.
//   XLEN, RADDR_W   : datapath and register index widths
//   fwd_sel_e       : operand source codes (RF, EX, MEM, WB)
//   slot_t          : one tracking slot {valid, rd, we, is_load}
//   SLOT_BUBBLE     : an empty slot
//   slot_writes()   : does a slot produce the register a source wants
// ---------------------------------------------------------------------------
package operand_forwarding_unit_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  // Source codes for a resolved operand; the encoding is visible on the
  // fwd_sel outputs so the numeric values matter.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // What the unit remembers about an instruction in flight.
  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] rd;
    logic               we;
    logic               is_load;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = slot_t'('0);

  // A slot can supply a source only if it is a real instruction that writes
  // the same non-zero register the consumer actually reads. x0 is never
  // forwarded because its architectural value is always zero.
  function automatic logic slot_writes(input slot_t              s,
                                       input logic [RADDR_W-1:0] rs,
                                       input logic               useRs);
    return s.valid && s.we && (s.rd == rs) && (rs != '0) && useRs;
  endfunction

endpackage

// File: rtl/operand_forwarding_unit_if.sv
// ---------------------------------------------------------------------------
// operand_forwarding_unit_if
// Bundles the decode-side, register-file and result buses of the forwarding
// stage.
//   master : pipeline side; drives decode fields, flush, rf read data and the
//            EX/MEM/WB results, receives operands, selects, stall and the
//            register file write port
//   slave  : the forwarding unit itself
// ---------------------------------------------------------------------------
interface operand_forwarding_unit_if;
  import operand_forwarding_unit_pkg::*;

  logic               id_valid;
  logic [RADDR_W-1:0] id_rs1;
  logic [RADDR_W-1:0] id_rs2;
  logic               id_use_rs1;
  logic               id_use_rs2;
  logic [RADDR_W-1:0] id_rd;
  logic               id_rd_we;
  logic               id_is_load;
  logic               flush;

  logic [XLEN-1:0]    rf_pa;
  logic [XLEN-1:0]    rf_pb;
  logic [XLEN-1:0]    ex_result;
  logic [XLEN-1:0]    mem_result;
  logic [XLEN-1:0]    wb_result;

  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    op_b;
  logic [1:0]         fwd_sel_a;
  logic [1:0]         fwd_sel_b;
  logic               stall;

  logic               rf_we;
  logic [RADDR_W-1:0] rf_rw;
  logic [XLEN-1:0]    rf_pw;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_rd_we, id_is_load, flush,
           rf_pa, rf_pb, ex_result, mem_result, wb_result,
    input  op_a, op_b, fwd_sel_a, fwd_sel_b, stall,
           rf_we, rf_rw, rf_pw
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_rd_we, id_is_load, flush,
           rf_pa, rf_pb, ex_result, mem_result, wb_result,
    output op_a, op_b, fwd_sel_a, fwd_sel_b, stall,
           rf_we, rf_rw, rf_pw
  );

endinterface

// File: rtl/operand_forwarding_unit_operand_select.sv
// ---------------------------------------------------------------------------
// operand_select
// Resolves one source operand against the three in-flight slots.
//   rs_i, use_i                      : source index and "really reads it"
//   ex_slot_i, mem_slot_i, wb_slot_i : tracking slots, youngest first
//   ex_result_i .. wb_result_i       : matching result buses
//   rf_value_i                       : register file read data
//   operand_o, fwd_sel_o             : resolved value and its source
//   load_hit_o                       : youngest producer is a load still in
//                                      EX, so the value does not exist yet
// Purely combinational.
// ---------------------------------------------------------------------------
module operand_select
  import operand_forwarding_unit_pkg::*;
(
  input  logic [RADDR_W-1:0] rs_i,
  input  logic               use_i,
  input  slot_t              ex_slot_i,
  input  slot_t              mem_slot_i,
  input  slot_t              wb_slot_i,
  input  logic [XLEN-1:0]    ex_result_i,
  input  logic [XLEN-1:0]    mem_result_i,
  input  logic [XLEN-1:0]    wb_result_i,
  input  logic [XLEN-1:0]    rf_value_i,
  output logic [XLEN-1:0]    operand_o,
  output fwd_sel_e           fwd_sel_o,
  output logic               load_hit_o
);

  logic exHit;
  logic memHit;
  logic wbHit;

  assign exHit  = slot_writes(ex_slot_i,  rs_i, use_i);
  assign memHit = slot_writes(mem_slot_i, rs_i, use_i);
  assign wbHit  = slot_writes(wb_slot_i,  rs_i, use_i);

  // Youngest producer wins. A load sitting in EX has no data yet, so it is
  // skipped for selection and reported as a load hit instead; the operand
  // then falls back to older producers, which is harmless because the
  // consumer is turned into a bubble while the stall is up.
  // WB must still be forwarded: the register file is written on the same
  // edge, so this cycle's read data is still the old value.
  always_comb begin
    operand_o  = rf_value_i;
    fwd_sel_o  = FWD_RF;
    load_hit_o = exHit && ex_slot_i.is_load;

    if (exHit && !ex_slot_i.is_load) begin
      operand_o = ex_result_i;
      fwd_sel_o = FWD_EX;
    end else if (memHit) begin
      operand_o = mem_result_i;
      fwd_sel_o = FWD_MEM;
    end else if (wbHit) begin
      operand_o = wb_result_i;
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/operand_forwarding_unit.sv
// ---------------------------------------------------------------------------
// operand_forwarding_unit
// Hazard tracking and operand forwarding stage placed after the register
// file. Tracks the destination of the instructions in EX, MEM and WB,
// replaces stale register file reads with in-flight results, raises a
// load-use stall, and drives the register file write port from WB.
//   clk   : pipeline clock, state advances on the rising edge
//   reset : synchronous, active-high; empties every tracking slot
//   bus   : operand_forwarding_unit_if.slave (decode fields, flush, rf read
//           data, EX/MEM/WB results in; operands, selects, stall and the rf
//           write port out)
// All outputs are combinational from the slots and the current inputs.
// ---------------------------------------------------------------------------
module operand_forwarding_unit
  import operand_forwarding_unit_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  operand_forwarding_unit_if.slave      bus
);

  slot_t           exSlot_q;
  slot_t           memSlot_q;
  slot_t           wbSlot_q;
  slot_t           exSlot_d;
  slot_t           memSlot_d;
  slot_t           wbSlot_d;
  slot_t           decodeEntry;

  logic            loadHitA;
  logic            loadHitB;
  logic            loadUse;
  fwd_sel_e        selA;
  fwd_sel_e        selB;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;

  // One resolver per source port; both look at the same slots.
  operand_select uSelA (
    .rs_i         (bus.id_rs1),
    .use_i        (bus.id_use_rs1),
    .ex_slot_i    (exSlot_q),
    .mem_slot_i   (memSlot_q),
    .wb_slot_i    (wbSlot_q),
    .ex_result_i  (bus.ex_result),
    .mem_result_i (bus.mem_result),
    .wb_result_i  (bus.wb_result),
    .rf_value_i   (bus.rf_pa),
    .operand_o    (opA),
    .fwd_sel_o    (selA),
    .load_hit_o   (loadHitA)
  );

  operand_select uSelB (
    .rs_i         (bus.id_rs2),
    .use_i        (bus.id_use_rs2),
    .ex_slot_i    (exSlot_q),
    .mem_slot_i   (memSlot_q),
    .wb_slot_i    (wbSlot_q),
    .ex_result_i  (bus.ex_result),
    .mem_result_i (bus.mem_result),
    .wb_result_i  (bus.wb_result),
    .rf_value_i   (bus.rf_pb),
    .operand_o    (opB),
    .fwd_sel_o    (selB),
    .load_hit_o   (loadHitB)
  );

  // Next-state for the tracking pipeline. The decode instruction enters EX
  // unless it is squashed by a flush or held back by a load-use stall, in
  // which case EX gets a bubble. A flush also suppresses the stall output,
  // since the instruction that wanted the load data no longer exists.
  always_comb begin
    loadUse     = loadHitA | loadHitB;
    decodeEntry = '{valid:   bus.id_valid,
                    rd:      bus.id_rd,
                    we:      bus.id_rd_we,
                    is_load: bus.id_is_load};
    exSlot_d    = (bus.flush || loadUse) ? SLOT_BUBBLE : decodeEntry;
    memSlot_d   = exSlot_q;
    wbSlot_d    = memSlot_q;
  end

  // Slot registers. Reset drops everything in flight, including a write
  // that would otherwise have reached the register file later.
  always_ff @(posedge clk) begin
    if (reset) begin
      exSlot_q  <= SLOT_BUBBLE;
      memSlot_q <= SLOT_BUBBLE;
      wbSlot_q  <= SLOT_BUBBLE;
    end else begin
      exSlot_q  <= exSlot_d;
      memSlot_q <= memSlot_d;
      wbSlot_q  <= wbSlot_d;
    end
  end

  // Output drive. Writes to x0 are suppressed here so the register file
  // never has to special-case index zero.
  always_comb begin
    bus.op_a      = opA;
    bus.op_b      = opB;
    bus.fwd_sel_a = selA;
    bus.fwd_sel_b = selB;
    bus.stall     = loadUse && !bus.flush;
    bus.rf_we     = wbSlot_q.valid && wbSlot_q.we && (wbSlot_q.rd != '0);
    bus.rf_rw     = wbSlot_q.rd;
    bus.rf_pw     = bus.wb_result;
  end

endmodule
